// File: rtl/branch_predictor.sv
// 2-bit saturating-counter direction predictor with registered mispredict flush; pred_taken is combinational, flush starts 1 cycle after a mispredict.
// No backpressure: one prediction and one update per cycle. Macro BP_STATS_EN enables the br_count/mispred_count statistics.
module branch_predictor #(
   parameter int IDX_BITS     = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pred_pc,
   input  logic [2:0]  pred_br_type,
   output logic        pred_taken,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [2:0]  upd_br_type,
   input  logic        upd_taken,
   input  logic        upd_pred,
   output logic        flush,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   localparam int         NUM_ENTRIES = 1 << IDX_BITS;
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_FLUSH    = 1'b1;
   localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

   function automatic logic is_cond(input logic [2:0] br_type);
      return (br_type != 3'b000) && (br_type != 3'b111);
   endfunction

   logic [NUM_ENTRIES-1:0][1:0] ctr_q, ctr_d;
   logic [IDX_BITS-1:0]         pred_idx, upd_idx;
   logic                        upd_en, mispred;
   logic [0:0]                  state_q, state_d;
   logic [3:0]                  fcnt_q, fcnt_d;
   logic                        unused_pc_bits;

   assign pred_idx = pred_pc[IDX_BITS+1:2];
   assign upd_idx  = upd_pc[IDX_BITS+1:2];
   assign upd_en   = upd_valid && is_cond(upd_br_type);
   assign mispred  = upd_valid && (upd_taken != upd_pred);
   assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                             upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

   // Reads the registered table, so a same-cycle update shows up next cycle.
   always_comb begin
      pred_taken = 1'b0;
      if (pred_br_type == 3'b111) begin
         pred_taken = 1'b1;
      end else if (is_cond(pred_br_type)) begin
         pred_taken = ctr_q[pred_idx][1];
      end
   end

   always_comb begin
      ctr_d = ctr_q;
      if (upd_en) begin
         if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
         end else begin
            if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
         end
      end
   end

   // A mispredict during FLUSH restarts the window from that event.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (state_q == ST_IDLE) begin
         if (mispred) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_LOAD;
         end
      end else begin
         if (mispred) begin
            fcnt_d = FLUSH_LOAD;
         end else if (fcnt_q == 4'd0) begin
            state_d = ST_IDLE;
         end else begin
            fcnt_d = fcnt_q - 4'd1;
         end
      end
   end

   assign flush = (state_q == ST_FLUSH);

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q   <= {NUM_ENTRIES{2'b01}};
         state_q <= ST_IDLE;
         fcnt_q  <= 4'd0;
      end else begin
         ctr_q   <= ctr_d;
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mis_cnt_q, mis_cnt_d;

   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (upd_en)  br_cnt_d  = br_cnt_q + 32'd1;
      if (mispred) mis_cnt_d = mis_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q  <= 32'd0;
         mis_cnt_q <= 32'd0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign br_count      = br_cnt_q;
   assign mispred_count = mis_cnt_q;
`else
   assign br_count      = 32'd0;
   assign mispred_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: counter training, aliasing, flush timing, reset priority, statistics.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pred_pc;
   logic [2:0]  pred_br_type;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [2:0]  upd_br_type;
   logic        upd_taken;
   logic        upd_pred;
   logic        flush;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   int n_cmp  = 0;
   int n_fail = 0;

   branch_predictor #(.IDX_BITS(4), .FLUSH_CYCLES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .pred_pc      (pred_pc),
      .pred_br_type (pred_br_type),
      .pred_taken   (pred_taken),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_br_type  (upd_br_type),
      .upd_taken    (upd_taken),
      .upd_pred     (upd_pred),
      .flush        (flush),
      .br_count     (br_count),
      .mispred_count(mispred_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [2:0] t, input logic tk, input logic pr);
      upd_valid   = 1'b1;
      upd_pc      = pc;
      upd_br_type = t;
      upd_taken   = tk;
      upd_pred    = pr;
   endtask

   task automatic no_upd();
      upd_valid   = 1'b0;
      upd_pc      = 32'h0;
      upd_br_type = 3'b000;
      upd_taken   = 1'b0;
      upd_pred    = 1'b0;
   endtask

   task automatic pred(input logic [31:0] pc, input logic [2:0] t);
      pred_pc      = pc;
      pred_br_type = t;
      settle();
   endtask

   initial begin
      rst = 1'b1;
      pred_pc = 32'h0;
      pred_br_type = 3'b000;
      no_upd();
      tick();
      tick();
      rst = 1'b0;
      settle();

      // Reset state
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_br_count", br_count, 32'd0);
      chk("rst_mis_count", mispred_count, 32'd0);
      pred(32'h40, 3'b001);  chk("rst_beq", {31'd0, pred_taken}, 32'd0);
      pred(32'h123, 3'b110); chk("rst_bge", {31'd0, pred_taken}, 32'd0);
      pred(32'h40, 3'b111);  chk("rst_jal", {31'd0, pred_taken}, 32'd1);
      pred(32'h40, 3'b000);  chk("rst_none", {31'd0, pred_taken}, 32'd0);

      // Training at 0x40: 01 -> 10 -> 11 -> 11; same-cycle read sees old value
      tick();
      upd(32'h40, 3'b001, 1'b1, 1'b1);
      pred(32'h40, 3'b001);  chk("bypass_old", {31'd0, pred_taken}, 32'd0);
      tick(); settle();      chk("train1", {31'd0, pred_taken}, 32'd1);
      upd(32'h40, 3'b011, 1'b1, 1'b1);
      tick(); settle();      chk("train2", {31'd0, pred_taken}, 32'd1);
      upd(32'h40, 3'b101, 1'b1, 1'b1);
      tick(); settle();      chk("train3_sat", {31'd0, pred_taken}, 32'd1);
      upd(32'h40, 3'b010, 1'b0, 1'b0);
      tick(); settle();      chk("nt1_still", {31'd0, pred_taken}, 32'd1);
      upd(32'h40, 3'b100, 1'b0, 1'b0);
      tick(); settle();      chk("nt2_flip", {31'd0, pred_taken}, 32'd0);
      chk("no_flush_train", {31'd0, flush}, 32'd0);

      // Aliasing: 0x80 shares the index of 0x40 (counter now 01 -> 11)
      upd(32'h80, 3'b001, 1'b1, 1'b1);
      tick();
      upd(32'h80, 3'b001, 1'b1, 1'b1);
      tick();
      // Non-conditional updates must not touch the 0x44 entry
      upd(32'h44, 3'b000, 1'b1, 1'b1);
      tick();
      upd(32'h44, 3'b111, 1'b1, 1'b1);
      tick();
      upd(32'h44, 3'b001, 1'b1, 1'b1);
      upd_valid = 1'b0;
      tick();
      no_upd();
      pred(32'h40, 3'b001);  chk("alias_40", {31'd0, pred_taken}, 32'd1);
      pred(32'h80, 3'b110);  chk("alias_80", {31'd0, pred_taken}, 32'd1);
      pred(32'h44, 3'b001);  chk("other_44", {31'd0, pred_taken}, 32'd0);

      // Single mispredict at cycle N
      upd(32'h100, 3'b001, 1'b1, 1'b0);
      settle();              chk("flush_N", {31'd0, flush}, 32'd0);
      tick(); no_upd(); settle(); chk("flush_N1", {31'd0, flush}, 32'd1);
      tick(); settle();      chk("flush_N2", {31'd0, flush}, 32'd1);
      tick(); settle();      chk("flush_N3", {31'd0, flush}, 32'd0);

      // Mispredict at N and again at N+2
      upd(32'h100, 3'b001, 1'b1, 1'b0);
      tick(); no_upd(); settle(); chk("ext_N1", {31'd0, flush}, 32'd1);
      tick();
      upd(32'h100, 3'b001, 1'b0, 1'b1);
      settle();              chk("ext_N2", {31'd0, flush}, 32'd1);
      tick(); no_upd(); settle(); chk("ext_N3", {31'd0, flush}, 32'd1);
      tick(); settle();      chk("ext_N4", {31'd0, flush}, 32'd1);
      tick(); settle();      chk("ext_N5", {31'd0, flush}, 32'd0);

      // Reset in the middle of a flush, with a competing mispredict/update
      upd(32'h104, 3'b001, 1'b1, 1'b0);
      tick();
      settle();              chk("rflush_N1", {31'd0, flush}, 32'd1);
      rst = 1'b1;
      upd(32'h104, 3'b001, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      no_upd();
      settle();              chk("rflush_N2", {31'd0, flush}, 32'd0);
      pred(32'h104, 3'b001); chk("rst_ctr_104", {31'd0, pred_taken}, 32'd0);
      pred(32'h40, 3'b001);  chk("rst_ctr_40", {31'd0, pred_taken}, 32'd0);
      tick(); settle();      chk("rflush_N3", {31'd0, flush}, 32'd0);
      upd(32'h40, 3'b001, 1'b1, 1'b1);
      tick(); no_upd();
      pred(32'h40, 3'b001);  chk("rst_ctr_01", {31'd0, pred_taken}, 32'd1);
      chk("rst_br_count2", br_count, 32'd0 + (`ifdef BP_STATS_EN 32'd1 `else 32'd0 `endif));
      chk("rst_mis_count2", mispred_count, 32'd0);

      // Statistics: 5 conditional updates, 2 mispredicts, 1 jal
      rst = 1'b1;
      tick();
      rst = 1'b0;
      upd(32'h200, 3'b001, 1'b1, 1'b1); tick();
      upd(32'h204, 3'b010, 1'b0, 1'b1); tick();
      upd(32'h208, 3'b011, 1'b1, 1'b1); tick();
      upd(32'h20c, 3'b100, 1'b1, 1'b0); tick();
      upd(32'h210, 3'b101, 1'b0, 1'b0); tick();
      upd(32'h214, 3'b111, 1'b1, 1'b1); tick();
      no_upd();
      tick(); settle();
`ifdef BP_STATS_EN
      chk("stats_br", br_count, 32'd5);
      chk("stats_mis", mispred_count, 32'd2);
`else
      chk("stats_br_off", br_count, 32'd0);
      chk("stats_mis_off", mispred_count, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, meaning log2 of the number of 2-bit counter entries (16 entries).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush stays asserted per mispredict (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pred_pc, input, 32, the fetch-stage PC to predict.
REQ-006 SHALL have port pred_br_type, input, 3, the branch type of the fetched instruction, encoded as 000 none, 001 beq, 010 bne, 011 bltu, 100 bgeu, 101 blt, 110 bge, 111 jal/jalr.
REQ-007 SHALL have port pred_taken, output, 1, the predicted direction for pred_pc.
REQ-008 SHALL have port upd_valid, input, 1, qualifying a resolved-branch update this cycle.
REQ-009 SHALL have port upd_pc, input, 32, the PC of the resolved instruction.
REQ-010 SHALL have port upd_br_type, input, 3, the branch type of the resolved instruction, using the same encoding as pred_br_type.
REQ-011 SHALL have port upd_taken, input, 1, the actual outcome from the branch comparator (br_taken).
REQ-012 SHALL have port upd_pred, input, 1, the prediction that was made for this instruction at fetch.
REQ-013 SHALL have port flush, output, 1, which is high while the pipeline must discard wrong-path instructions.
REQ-014 SHALL have port br_count, output, 32, counting resolved conditional branches.
REQ-015 SHALL have port mispred_count, output, 32, counting mispredicts.

Function
REQ-016 SHALL hold 2**IDX_BITS 2-bit saturating counters indexed by pc[IDX_BITS+1:2], with pc[1:0] ignored.
REQ-017 SHALL drive pred_taken combinationally: counter[1] for types 001..110, 1 for type 111, and 0 for type 000.
REQ-018 SHALL update the indexed counter on the clock edge when upd_valid=1 and upd_br_type is 001..110: increment saturating at 11 if upd_taken=1, else decrement saturating at 00.
REQ-019 SHALL leave all counters unchanged for upd_br_type 000 or 111, or when upd_valid=0.
REQ-020 SHALL, when the prediction and update indices match in the same cycle, return the pre-update counter value on pred_taken; the new value is visible in the next cycle.
REQ-021 SHALL detect a mispredict when upd_valid=1 and upd_taken != upd_pred, for any upd_br_type.
REQ-022 SHALL implement a flush FSM with states IDLE and FLUSH and a 4-bit down-counter:
- IDLE -> FLUSH on a mispredict, loading the counter with FLUSH_CYCLES-1;
- FLUSH decrements the counter each cycle and returns to IDLE after the cycle in which the counter is 0.
REQ-023 SHALL assert flush while in state FLUSH, i.e. registered and starting exactly 1 cycle after the mispredict cycle, for FLUSH_CYCLES cycles.
REQ-024 SHALL, on a new mispredict while in FLUSH, reload the counter so that flush extends FLUSH_CYCLES cycles beyond that event.
REQ-025 SHALL perform the counter update even when a mispredict occurs in the same cycle.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set all counters to 01 (weakly not-taken), set the FSM to IDLE, clear the flush down-counter, drive flush=0, and clear br_count and mispred_count to 0.
REQ-027 SHALL give rst priority over any simultaneous update or mispredict, including when reset is asserted in the middle of a flush.
REQ-028 SHALL drive pred_taken after reset per REQ-017 from the reset counter values, giving 0 for conditional branch types.

Configuration
REQ-029 SHALL gate the statistics counters with macro BP_STATS_EN.
REQ-030 SHALL, when BP_STATS_EN is defined:
- increment br_count on each update per REQ-018;
- increment mispred_count on each mispredict per REQ-021;
- wrap both counters modulo 2**32.
REQ-031 SHALL, when BP_STATS_EN is undefined, tie br_count and mispred_count to constant 0 and implement no counter registers.

Verification
REQ-032 SHALL cover: reset, then pred_br_type=001 at any PC -> pred_taken=0; pred_br_type=111 -> pred_taken=1; pred_br_type=000 -> pred_taken=0.
REQ-033 SHALL cover: three taken updates to PC 0x40 (counter 01->10->11->11) -> pred_taken=1 at 0x40; one not-taken update -> still 1; a second not-taken update -> 0.
REQ-034 SHALL cover: PC 0x40 and PC 0x80 (same index with IDX_BITS=4) -> both PCs share one prediction (alias); PC 0x44 is unaffected.
REQ-035 SHALL cover: upd_valid with upd_pred=0 and upd_taken=1 at cycle N -> flush=1 in cycles N+1 and N+2 and 0 in N+3; a second mispredict at N+2 -> flush held high through N+4.
REQ-036 SHALL cover: rst asserted at cycle N+1 during a flush -> flush=0 from N+2, and counters read 01.
REQ-037 SHALL cover, with BP_STATS_EN defined: 5 conditional updates including 2 mispredicts, plus 1 jal update -> br_count=5 and mispred_count=2. With BP_STATS_EN undefined, both outputs read 0.
